// File: rtl/mole_round_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mole_round_scheduler
// Description : Runs one whack-a-mole round: countdown, mole placement,
//               mole lifetime and hit/miss resolution.
// Revision    : 1.0 - initial release
// ============================================================================
module mole_round_scheduler #(
  parameter int NUM_MOLES  = 5,
  parameter int GAME_TICKS = 30,
  parameter int LIFE_TICKS = 2,
  parameter int GAP_TICKS  = 1,
  parameter int TIMER_W    = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 tick,
  input  logic [7:0]           rand_in,
  input  logic [NUM_MOLES-1:0] button_pulse,
  output logic                 active,
  output logic [NUM_MOLES-1:0] mole_mask,
  output logic                 hit,
  output logic                 miss,
  output logic                 timer_expired,
  output logic [TIMER_W-1:0]   time_left
);

  localparam int IDX_W  = $clog2(NUM_MOLES);
  localparam int LIFE_W = $clog2(LIFE_TICKS + 1);
  localparam int GAP_W  = $clog2(GAP_TICKS + 1);

  localparam logic [TIMER_W-1:0]   c_game    = TIMER_W'(GAME_TICKS);
  localparam logic [LIFE_W-1:0]    c_life    = LIFE_W'(LIFE_TICKS);
  localparam logic [GAP_W-1:0]     c_gap     = GAP_W'(GAP_TICKS);
  localparam logic [IDX_W-1:0]     c_max_idx = IDX_W'(NUM_MOLES - 1);
  localparam logic [NUM_MOLES-1:0] c_one     = NUM_MOLES'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAP  = 2'd1,
    S_UP   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state, w_state;
  logic [TIMER_W-1:0]   r_time_left, w_time_left;
  logic [GAP_W-1:0]     r_gap_cnt, w_gap_cnt;
  logic [LIFE_W-1:0]    r_life_cnt, w_life_cnt;
  logic [IDX_W-1:0]     r_last_idx, w_last_idx;
  logic [NUM_MOLES-1:0] r_mole_mask, w_mole_mask;
  logic                 r_active, w_active;
  logic                 r_hit, w_hit;
  logic                 r_miss, w_miss;
  logic                 r_expired, w_expired;

  logic [IDX_W-1:0]     w_raw_idx;
  logic [IDX_W-1:0]     w_pick_idx;
  logic                 w_whack;
  logic                 w_running;

  // Never show the same hole twice in a row: bump a repeat to the next hole.
  assign w_raw_idx  = IDX_W'(rand_in % 8'(NUM_MOLES));
  assign w_pick_idx = (w_raw_idx != r_last_idx) ? w_raw_idx :
                      (w_raw_idx == c_max_idx)  ? '0 : w_raw_idx + 1'b1;
  assign w_whack    = |(button_pulse & r_mole_mask);
  assign w_running  = (r_state == S_GAP) || (r_state == S_UP);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_time_left <= '0;
      r_gap_cnt   <= '0;
      r_life_cnt  <= '0;
      r_last_idx  <= '0;
      r_mole_mask <= '0;
      r_active    <= 1'b0;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
      r_expired   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_time_left <= w_time_left;
      r_gap_cnt   <= w_gap_cnt;
      r_life_cnt  <= w_life_cnt;
      r_last_idx  <= w_last_idx;
      r_mole_mask <= w_mole_mask;
      r_active    <= w_active;
      r_hit       <= w_hit;
      r_miss      <= w_miss;
      r_expired   <= w_expired;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_time_left = r_time_left;
    w_gap_cnt   = r_gap_cnt;
    w_life_cnt  = r_life_cnt;
    w_last_idx  = r_last_idx;
    w_mole_mask = r_mole_mask;
    w_hit       = 1'b0;
    w_miss      = 1'b0;
    w_expired   = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        w_mole_mask = '0;
        if (start) begin
          w_time_left = c_game;
          w_gap_cnt   = c_gap;
          w_state     = S_GAP;
        end
      end
      S_GAP: begin
        w_mole_mask = '0;
        if (tick) begin
          if (r_gap_cnt == GAP_W'(1)) begin
            w_state     = S_UP;
            w_last_idx  = w_pick_idx;
            w_mole_mask = c_one << w_pick_idx;
            w_life_cnt  = c_life;
          end else begin
            w_gap_cnt = r_gap_cnt - GAP_W'(1);
          end
        end
      end
      S_UP: begin
        if (w_whack) begin
          w_hit       = 1'b1;
          w_mole_mask = '0;
          w_gap_cnt   = c_gap;
          w_state     = S_GAP;
        end else if (tick) begin
          if (r_life_cnt == LIFE_W'(1)) begin
            w_miss      = 1'b1;
            w_mole_mask = '0;
            w_gap_cnt   = c_gap;
            w_state     = S_GAP;
          end else begin
            w_life_cnt = r_life_cnt - LIFE_W'(1);
          end
        end
      end
      default: begin
        w_state     = S_IDLE;
        w_mole_mask = '0;
      end
    endcase

    // The round clock runs through both live states; its last tick wins over
    // mole placement and misses, but a same-cycle hit still counts.
    if (w_running && tick) begin
      w_time_left = r_time_left - TIMER_W'(1);
      if (r_time_left == TIMER_W'(1)) begin
        w_expired   = 1'b1;
        w_miss      = 1'b0;
        w_mole_mask = '0;
        w_last_idx  = r_last_idx;
        w_life_cnt  = r_life_cnt;
        w_state     = S_DONE;
      end
    end

    w_active = (w_state == S_GAP) || (w_state == S_UP);
  end

  assign active        = r_active;
  assign mole_mask     = r_mole_mask;
  assign hit           = r_hit;
  assign miss          = r_miss;
  assign timer_expired = r_expired;
  assign time_left     = r_time_left;

endmodule
`default_nettype wire
